// File: rtl/ahb_bram_pkg.sv
// Shared encodings for the AHB-Lite to block-RAM bridge: FSM states and AHB field codes.
package ahb_bram_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_DATA = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_RD_WAIT = 3'd3,
    ST_ERR1    = 3'd4,
    ST_ERR2    = 3'd5
  } state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

endpackage

// File: rtl/ahb_bram_lane_dec.sv
// Byte-lane decoder: HSIZE + low address bits -> RAM write mask, flags unaligned/oversize transfers.
// Purely combinational; illegal transfers yield an all-zero mask.
module ahb_bram_lane_dec
  import ahb_bram_pkg::*;
(
  input  logic [2:0] hsize,
  input  logic [1:0] addr_lo,
  output logic [3:0] mask,
  output logic       illegal
);

  always_comb begin
    mask    = 4'b0000;
    illegal = 1'b0;
    case (hsize)
      HSIZE_BYTE: mask = 4'b0001 << addr_lo;
      HSIZE_HALF: begin
        if (addr_lo[0]) illegal = 1'b1;
        else            mask    = addr_lo[1] ? 4'b1100 : 4'b0011;
      end
      HSIZE_WORD: begin
        if (addr_lo != 2'b00) illegal = 1'b1;
        else                  mask    = 4'b1111;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ahb_bram_ctrl.sv
// AHB-Lite subordinate onto a 1-cycle-latency block RAM port: zero-wait reads, writes posted in the data phase.
// Only stall: one wait state when a read follows a write directly (RAM port busy with the write); errors take two cycles.
module ahb_bram_ctrl
  import ahb_bram_pkg::*;
#(
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clka,
  input  logic                  rsta,
  input  logic                  HSEL,
  input  logic [31:0]           HADDR,
  input  logic [1:0]            HTRANS,
  input  logic [2:0]            HSIZE,
  input  logic                  HWRITE,
  input  logic                  HREADY,
  input  logic [31:0]           HWDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [31:0]           HRDATA,
  output logic [ADDR_WIDTH-1:0] addra,
  output logic [31:0]           dina,
  output logic [3:0]            wea,
  input  logic [31:0]           douta
);

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [3:0]            mask_q;
  logic [ADDR_WIDTH-1:0] haddr_word;
  logic [3:0]            lane_mask;
  logic                  illegal;
  logic                  accept;
  logic                  take;
  logic                  unused_haddr;

  assign haddr_word   = HADDR[ADDR_WIDTH+1:2];
  assign unused_haddr = ^HADDR[31:ADDR_WIDTH+2];
  assign accept       = HSEL & HREADY & ((HTRANS == HTRANS_NONSEQ) | (HTRANS == HTRANS_SEQ));
  // RD_WAIT and ERR1 own the bus with HREADYOUT low, so nothing new is taken there.
  assign take         = accept & (state != ST_RD_WAIT) & (state != ST_ERR1);

  ahb_bram_lane_dec u_lane_dec (
    .hsize   (HSIZE),
    .addr_lo (HADDR[1:0]),
    .mask    (lane_mask),
    .illegal (illegal)
  );

  always_ff @(posedge clka) begin
    if (rsta) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // One address latch serves both the posted write and a read parked behind it.
  always_ff @(posedge clka) begin
    if (rsta) begin
      addr_q <= '0;
      mask_q <= 4'b0000;
    end else if (take) begin
      addr_q <= haddr_word;
      mask_q <= lane_mask;
    end
  end

  always_comb begin
    state_nxt = ST_IDLE;
    case (state)
      ST_RD_WAIT: state_nxt = ST_RD_DATA;
      ST_ERR1:    state_nxt = ST_ERR2;
      default: begin
        if (take) begin
          if (illegal)                  state_nxt = ST_ERR1;
          else if (HWRITE)              state_nxt = ST_WR_DATA;
          else if (state == ST_WR_DATA) state_nxt = ST_RD_WAIT;
          else                          state_nxt = ST_RD_DATA;
        end
      end
    endcase
  end

  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = HRESP_OKAY;
    HRDATA    = '0;
    wea       = 4'b0000;
    dina      = HWDATA;
    addra     = haddr_word;
    case (state)
      ST_WR_DATA: begin
        wea   = mask_q;
        addra = addr_q;
      end
      ST_RD_WAIT: begin
        HREADYOUT = 1'b0;
        addra     = addr_q;
      end
      ST_RD_DATA: HRDATA = douta;
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = HRESP_ERROR;
      end
      ST_ERR2: HRESP = HRESP_ERROR;
      default: ;
    endcase
    // A write whose data phase meets reset must never reach the RAM.
    if (rsta) begin
      wea       = 4'b0000;
      HREADYOUT = 1'b1;
      HRESP     = HRESP_OKAY;
      HRDATA    = '0;
    end
  end

endmodule
